ancho_capture: RTL and testbench
================================

# ancho_capture

PWM capture block: the receive-side counterpart of the team's configurable-duty PWM generator. It synchronises an incoming PWM pin and measures, for every full period, the high time and the period length in `clk` cycles. From those two values it computes a 3-bit duty code, floor(8·high/period), which is the same duty scale the generator takes on its `speed` input. It sits in the tt_um top level, with `pwm_in` on a `ui_in` pin and the results on `uo_out`/`uio_out`, so a bench or a second chip can loop the generator back and check it.

## Interface
- `CNT_W`, default 16: width of the high and period counters; values saturate at 2^CNT_W−1.
- `clk` input 1: single clock; everything is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: synchronous enable; low means idle and disarmed.
- `pwm_in` input 1: asynchronous PWM pin; passes through a 2-flop synchroniser.
- `high_time` output CNT_W: cycles high in the last measured period.
- `period` output CNT_W: cycles between the last two rising edges.
- `duty_code` output 3: floor(8·high_time/period).
- `valid` output 1: one-cycle pulse when all three results update together.
- `stuck` output 1: no rising edge seen for 2^CNT_W−1 cycles (timeout build only).

## Operation
- **Input conditioning:** `pwm_in` goes through sync1 then sync2. A rising edge is sync2=1 with its previous value 0.
- **FSM state ARM (entered from reset, from `ena` low, or from timeout):** the first rising edge loads p_cnt=1 and h_cnt=1, then moves to MEASURE. No capture happens on this edge.
- **FSM state MEASURE, every cycle:**
  - p_cnt increments, saturating.
  - h_cnt increments while sync2=1, saturating.
- **FSM state MEASURE, on a rising edge (the capture):**
  - Latch hi_l=h_cnt and per_l=p_cnt.
  - Reload p_cnt=1 and h_cnt=1.
  - If per_l ≥ 4, start the divider. If per_l < 4, discard the capture: no `valid`, outputs unchanged.
- **Divider:** 3-step restoring division with a (CNT_W+1)-bit remainder.
  - rem starts at hi_l.
  - Each step: rem = rem<<1; if rem ≥ per_l then bit = 1 and rem −= per_l; else bit = 0.
  - Bits are produced MSB first.
  - hi_l < per_l always holds, so the result is 0..7 and needs no clamping.
- **Result update:** at the third divider step, `high_time`, `period`, `duty_code` update together and `valid` pulses.
- **Divider cannot overrun:** the minimum accepted period of 4 guarantees the divider is idle at the next capture.
- **`ena` low:**
  - Next edge: state goes to ARM, counters clear, divider aborts, `valid` is 0.
  - `high_time`, `period` and `duty_code` hold.
  - `stuck` clears.
- **Reset:** all outputs are 0, state is ARM, sync flops are 0.
- **Reset mid-divide:** the result is lost and outputs read 0 immediately.

## Timing
- **Latency:** `pwm_in` rise sampled at edge S, capture at edge S+2, outputs and `valid` registered at edge S+5.
- **`valid` width:** exactly 1 cycle per accepted period. Consecutive pulses are at least 4 cycles apart.
- **Output stability:** the outputs stay stable between `valid` pulses.
- **Timeout:** p_cnt reaching 2^CNT_W−1 in MEASURE gives, at the next edge, `stuck`=1 and state ARM.
- **Clearing `stuck`:** it clears together with the next `valid` pulse.

## Configuration
- Macro: `ANCHO_CAPTURE_TIMEOUT_EN`.
- **Defined:** timeout detection as described above.
- **Undefined:**
  - `stuck` is tied 0 and there is no timeout transition.
  - The FSM stays in MEASURE with saturated counters.
  - The next rising edge captures the saturated values and produces a normal `valid`.

## Structure
- **Package `ancho_pkg`:**
  - CNT_W default.
  - DUTY_W=3.
  - MIN_PERIOD=4.
  - FSM state enum {ARM, MEASURE}.
- **Sub-module `ancho_div3`:**
  - Inputs: start, num, den.
  - Outputs: 3-bit quotient, done; plus a busy flag.
  - Behaviour: 3-cycle sequential restoring divider, synchronous abort input.
- **Top `ancho_capture`:** synchroniser, counters, FSM, output registers.

## Test plan
- **Nominal duty:** period 8, high 3, steady → after the arming edge, `valid` once every 8 cycles with high_time=3, period=8, duty_code=3.
- **Extreme duty:**
  - high 1 of 16 → duty_code=0.
  - high 15 of 16 → duty_code=7.
  - high 8 of 16 → duty_code=4.
- **Short periods:** period 3 for 10 pulses → no `valid` and outputs unchanged. Then period 4, high 2 → duty_code=4.
- **Timeout (CNT_W=8, macro defined):** hold `pwm_in` low → `stuck`=1 exactly 255 cycles after the last rise. The next rise only arms. The following rise gives `valid`=1 and `stuck`=0.
- **Enable drop:** `ena` low mid-period → no `valid` and outputs hold. After `ena` returns high, two rises are needed for the first `valid`.
- **Reset mid-divide:** `rst_n` low between capture and result → all outputs 0 asynchronously and no `valid` after release.

Source files
------------

// File: rtl/ancho_pkg.sv
// Shared constants and types for the PWM capture block.
// Imported by the divider and the capture top.
package ancho_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int DUTY_W        = 3;
    localparam int MIN_PERIOD    = 4;

    typedef enum logic {
        ARM,
        MEASURE
    } state_t;

endpackage

// File: rtl/ancho_div3.sv
// Three-step restoring divider producing the duty code MSB first.
// Assumes num < den, so the quotient always fits in DUTY_W bits.
module ancho_div3
    import ancho_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic [DUTY_W-1:0] quotient,
    output logic              done,
    output logic              busy
);

    logic [CNT_W:0]    rem;
    logic [CNT_W:0]    rem_sh;
    logic [CNT_W:0]    rem_nx;
    logic [CNT_W-1:0]  den_r;
    logic [DUTY_W-2:0] q;
    logic [1:0]        step;
    logic              ge;

    always_comb begin
        rem_sh = rem << 1;
        ge     = (rem_sh >= {1'b0, den_r});
        rem_nx = ge ? (rem_sh - {1'b0, den_r}) : rem_sh;
    end

    // Final bit is taken combinationally so the result lands on the third step.
    assign quotient = {q, ge};
    assign done     = busy && (step == 2'(DUTY_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            den_r <= '0;
            q     <= '0;
            step  <= '0;
            busy  <= 1'b0;
        end else if (abort) begin
            step <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem   <= {1'b0, num};
            den_r <= den;
            q     <= '0;
            step  <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            rem  <= rem_nx;
            q    <= {q[DUTY_W-3:0], ge};
            step <= step + 2'd1;
            if (step == 2'(DUTY_W - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ancho_capture.sv
// PWM capture: measures high time and period per cycle and derives a duty code.
// Optional timeout detection is enabled by ANCHO_CAPTURE_TIMEOUT_EN.
module ancho_capture
    import ancho_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_time,
    output logic [CNT_W-1:0]  period,
    output logic [DUTY_W-1:0] duty_code,
    output logic              valid,
    output logic              stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);

    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              rise;
    state_t            state;
    logic [CNT_W-1:0]  p_cnt;
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  p_inc;
    logic [CNT_W-1:0]  h_inc;
    logic [CNT_W-1:0]  hi_l;
    logic [CNT_W-1:0]  per_l;
    logic              div_start;
    logic              div_done;
    logic              div_busy;
    logic [DUTY_W-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise  = sync2 & ~sync3;
    assign p_inc = (p_cnt == CNT_MAX) ? p_cnt : p_cnt + ONE;
    assign h_inc = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + ONE;

    // Periods shorter than MIN_P are dropped so the divider is never overrun.
    assign div_start = ena && (state == MEASURE) && rise
                    && (p_cnt >= MIN_P) && !div_busy;

    ancho_div3 #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .abort   (~ena),
        .num     (h_cnt),
        .den     (p_cnt),
        .quotient(div_q),
        .done    (div_done),
        .busy    (div_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARM;
            p_cnt     <= '0;
            h_cnt     <= '0;
            hi_l      <= '0;
            per_l     <= '0;
            high_time <= '0;
            period    <= '0;
            duty_code <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!ena) begin
                state <= ARM;
                p_cnt <= '0;
                h_cnt <= '0;
            end else begin
                if (div_done) begin
                    high_time <= hi_l;
                    period    <= per_l;
                    duty_code <= div_q;
                    valid     <= 1'b1;
                end
                case (state)
                    ARM: begin
                        if (rise) begin
                            p_cnt <= ONE;
                            h_cnt <= ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            p_cnt <= ONE;
                            h_cnt <= ONE;
                            if (div_start) begin
                                hi_l  <= h_cnt;
                                per_l <= p_cnt;
                            end
`ifdef ANCHO_CAPTURE_TIMEOUT_EN
                        end else if (p_cnt == CNT_MAX) begin
                            state <= ARM;
                            p_cnt <= '0;
                            h_cnt <= '0;
`endif
                        end else begin
                            p_cnt <= p_inc;
                            if (sync2) begin
                                h_cnt <= h_inc;
                            end
                        end
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

`ifdef ANCHO_CAPTURE_TIMEOUT_EN
    logic stuck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_q <= 1'b0;
        end else if (!ena || div_done) begin
            stuck_q <= 1'b0;
        end else if (state == MEASURE && !rise && p_cnt == CNT_MAX) begin
            stuck_q <= 1'b1;
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_ancho_capture.sv
// Directed and randomized bench for ancho_capture with a waveform-level model.
// Expected results come from rise positions and high-sample counts.
module tb_ancho_capture;

    localparam int W    = 8;
    localparam int SAT  = 255;
    localparam int MAXC = 4096;
`ifdef ANCHO_CAPTURE_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    typedef struct {
        int due;
        int ht;
        int pr;
        int dc;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         pwm_in;
    logic [W-1:0] high_time;
    logic [W-1:0] period;
    logic [2:0]   duty_code;
    logic         valid;
    logic         stuck;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   w [0:MAXC-1];
    bit   armed    = 1'b0;
    int   lr       = 0;
    int   stuck_due = -1;
    int   clr_at   = -1;
    res_t pend [$];

    logic         exp_valid = 1'b0;
    logic         exp_stuck = 1'b0;
    logic [W-1:0] exp_ht    = '0;
    logic [W-1:0] exp_pr    = '0;
    logic [2:0]   exp_dc    = '0;

    ancho_capture #(
        .CNT_W(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .pwm_in   (pwm_in),
        .high_time(high_time),
        .period   (period),
        .duty_code(duty_code),
        .valid    (valid),
        .stuck    (stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic check_all();
        check("valid", 32'(valid), 32'(exp_valid));
        check("high_time", 32'(high_time), 32'(exp_ht));
        check("period", 32'(period), 32'(exp_pr));
        check("duty_code", 32'(duty_code), 32'(exp_dc));
        check("stuck", 32'(stuck), 32'(exp_stuck));
    endtask

    task automatic step(input bit p, input bit e);
        int   rr;
        int   h;
        int   pr;
        res_t r;
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        exp_valid = 1'b0;
        if (stuck_due == cyc) exp_stuck = 1'b1;
        if (clr_at == cyc) exp_stuck = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            exp_ht    = W'(r.ht);
            exp_pr    = W'(r.pr);
            exp_dc    = 3'(r.dc);
            exp_valid = 1'b1;
            exp_stuck = 1'b0;
        end
        #1;
        pwm_in = p;
        ena    = e;
        w[cyc] = p;
        if (!e) begin
            armed = 1'b0;
            while (pend.size() > 0 && pend[$].due > cyc) void'(pend.pop_back());
            clr_at = cyc + 1;
        end else begin
            rr = cyc - 2;
            if (rr >= 1 && w[rr] && !w[rr-1]) begin
                if (armed) begin
                    pr = (rr - lr > SAT) ? SAT : rr - lr;
                    h = 0;
                    for (int i = lr; i < rr; i++) h += int'(w[i]);
                    if (h > SAT) h = SAT;
                    if (pr >= 4) pend.push_back('{rr + 6, h, pr, (8 * h) / pr});
                end
                armed = 1'b1;
                lr    = rr;
            end else if (armed && TO && rr == lr + SAT) begin
                armed     = 1'b0;
                stuck_due = cyc + 1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse(input int hi, input int per, input int n);
        repeat (n) begin
            for (int i = 0; i < per; i++) step(i < hi, 1'b1);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        #1;
        pend.delete();
        armed     = 1'b0;
        stuck_due = -1;
        clr_at    = -1;
        exp_valid = 1'b0;
        exp_stuck = 1'b0;
        exp_ht    = '0;
        exp_pr    = '0;
        exp_dc    = '0;
        check_all();
        repeat (2) begin
            @(posedge clk);
            cyc++;
            w[cyc] = 1'b0;
        end
        #1 rst_n = 1'b1;
        w[cyc] = 1'b0;
    endtask

    initial begin
        int per;
        int hi;
        rst_n  = 1'b0;
        ena    = 1'b0;
        pwm_in = 1'b0;
        for (int i = 0; i < MAXC; i++) w[i] = 1'b0;
        #3;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena   = 1'b1;

        // nominal 3/8
        pulse(3, 8, 10);
        // extreme duties over 16
        pulse(1, 16, 4);
        pulse(15, 16, 4);
        pulse(8, 16, 4);
        // short periods dropped, then the minimum period
        pulse(1, 3, 10);
        pulse(2, 4, 4);
        // long low stretch: timeout or counter saturation
        pulse(3, 8, 2);
        repeat (300) step(1'b0, 1'b1);
        pulse(3, 8, 3);
        // enable drop mid-period
        pulse(4, 10, 3);
        repeat (4) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        pulse(4, 10, 3);
        // random periods and duties
        repeat (25) begin
            per = int'($urandom_range(2, 20));
            hi  = int'($urandom_range(1, per - 1));
            pulse(hi, per, 1);
        end
        // reset between capture and result
        pulse(3, 8, 3);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        do_reset();
        pulse(3, 8, 4);
        repeat (8) step(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
